// File: rtl/mc_controller.sv
//==============================================================================
// mc_controller
//   Multicycle ARM-subset controller: one FSM sequences each instruction and
//   drives the shared-memory datapath enables; holds NZCV and the latched
//   condition check. Multi-cycle MUL is built only when MC_MUL_EN is defined.
// Revision: 1.0 - initial release
//==============================================================================
`default_nettype none

module mc_controller #(
    parameter int         MUL_LAT     = 4,
    parameter logic [3:0] RESET_FLAGS = 4'b0000
) (
    input  logic        clk,
    input  logic        reset,
    input  logic [31:0] Instr,
    input  logic [3:0]  ALUFlags,
    output logic        PCWrite,
    output logic        AdrSrc,
    output logic        MemWrite,
    output logic        IRWrite,
    output logic [1:0]  ResultSrc,
    output logic        ALUSrcA,
    output logic [1:0]  ALUSrcB,
    output logic [1:0]  RegSrc,
    output logic        RegWrite,
    output logic [1:0]  ImmSrc,
    output logic [2:0]  ALUControl,
    output logic        MulSel,
    output logic        Busy,
    output logic        Illegal,
    output logic [3:0]  State
);

    typedef enum logic [3:0] {
        S_FETCH   = 4'd0,
        S_DECODE  = 4'd1,
        S_MEMADR  = 4'd2,
        S_MEMRD   = 4'd3,
        S_MEMWB   = 4'd4,
        S_MEMWR   = 4'd5,
        S_EXECR   = 4'd6,
        S_EXECI   = 4'd7,
        S_ALUWB   = 4'd8,
        S_BRANCH  = 4'd9,
        S_UNKNOWN = 4'd10,
        S_EXECM   = 4'd11
    } state_t;

    state_t     r_state;
    logic [3:0] r_flags;
    logic       r_condex;
    logic [3:0] r_mul_cnt;

    logic [1:0] w_op;
    logic [3:0] w_cmd;
    logic       w_cmd_ok;
    logic       w_is_mul;
    logic [2:0] w_alu_dec;
    logic       w_condex;
    logic       w_setflags;
    logic       w_regw;
    logic       w_memw;
    logic       w_br;
    logic       w_unused;

    assign w_op       = Instr[27:26];
    assign w_cmd      = Instr[24:21];
    assign w_setflags = Instr[20] & r_condex;
    assign w_unused   = ^{Instr[19:16], Instr[11:8], Instr[7:4], Instr[3:0]};

`ifdef MC_MUL_EN
    assign w_is_mul = (Instr[27:22] == 6'b000000) && (Instr[7:4] == 4'b1001);
`else
    assign w_is_mul = 1'b0;
`endif

    always_comb begin
        w_cmd_ok  = 1'b1;
        w_alu_dec = 3'b000;
        case (w_cmd)
            4'b0100: w_alu_dec = 3'b000;
            4'b0010: w_alu_dec = 3'b001;
            4'b0000: w_alu_dec = 3'b010;
            4'b1100: w_alu_dec = 3'b011;
            default: w_cmd_ok  = 1'b0;
        endcase
    end

    // Flags are NZCV = [3:0]
    always_comb begin
        w_condex = 1'b0;
        case (Instr[31:28])
            4'b0000: w_condex = r_flags[2];
            4'b0001: w_condex = ~r_flags[2];
            4'b0010: w_condex = r_flags[1];
            4'b0011: w_condex = ~r_flags[1];
            4'b0100: w_condex = r_flags[3];
            4'b0101: w_condex = ~r_flags[3];
            4'b0110: w_condex = r_flags[0];
            4'b0111: w_condex = ~r_flags[0];
            4'b1000: w_condex = r_flags[1] & ~r_flags[2];
            4'b1001: w_condex = ~r_flags[1] | r_flags[2];
            4'b1010: w_condex = (r_flags[3] == r_flags[0]);
            4'b1011: w_condex = (r_flags[3] != r_flags[0]);
            4'b1100: w_condex = ~r_flags[2] & (r_flags[3] == r_flags[0]);
            4'b1101: w_condex = r_flags[2] | (r_flags[3] != r_flags[0]);
            4'b1110: w_condex = 1'b1;
            default: w_condex = 1'b0;
        endcase
    end

    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            r_state   <= S_FETCH;
            r_flags   <= RESET_FLAGS;
            r_condex  <= 1'b0;
            r_mul_cnt <= 4'd0;
        end else begin
            case (r_state)
                S_FETCH:  r_state <= S_DECODE;
                S_DECODE: begin
                    r_condex <= w_condex;
                    if (w_is_mul) begin
                        r_state   <= S_EXECM;
                        r_mul_cnt <= 4'(MUL_LAT - 1);
                    end else begin
                        case (w_op)
                            2'b01:   r_state <= S_MEMADR;
                            2'b10:   r_state <= S_BRANCH;
                            2'b00:   r_state <= !w_cmd_ok ? S_UNKNOWN :
                                                (Instr[25] ? S_EXECI : S_EXECR);
                            default: r_state <= S_UNKNOWN;
                        endcase
                    end
                end
                S_MEMADR: r_state <= Instr[20] ? S_MEMRD : S_MEMWR;
                S_MEMRD:  r_state <= S_MEMWB;
                S_EXECR, S_EXECI: begin
                    r_state <= S_ALUWB;
                    if (w_setflags) begin
                        if (w_cmd == 4'b0100 || w_cmd == 4'b0010)
                            r_flags <= ALUFlags;
                        else
                            r_flags[3:2] <= ALUFlags[3:2];
                    end
                end
                // Counter was loaded with MUL_LAT-1, giving MUL_LAT cycles here
                S_EXECM: begin
                    if (r_mul_cnt == 4'd0) begin
                        r_state <= S_ALUWB;
                        if (w_setflags)
                            r_flags[3:2] <= ALUFlags[3:2];
                    end else begin
                        r_mul_cnt <= r_mul_cnt - 4'd1;
                    end
                end
                default:  r_state <= S_FETCH;
            endcase
        end
    end

    always_comb begin
        AdrSrc     = 1'b0;
        ResultSrc  = 2'b00;
        ALUSrcA    = 1'b0;
        ALUSrcB    = 2'b00;
        RegSrc     = 2'b00;
        ALUControl = 3'b000;
        Illegal    = 1'b0;
        w_regw     = 1'b0;
        w_memw     = 1'b0;
        w_br       = 1'b0;
        case (r_state)
            S_FETCH, S_DECODE: begin
                ALUSrcA   = 1'b1;
                ALUSrcB   = 2'b10;
                ResultSrc = 2'b10;
            end
            S_MEMADR: begin
                ALUSrcB    = 2'b01;
                ALUControl = Instr[23] ? 3'b000 : 3'b001;
            end
            S_MEMRD:  AdrSrc = 1'b1;
            S_MEMWB: begin
                ResultSrc = 2'b01;
                w_regw    = 1'b1;
            end
            S_MEMWR: begin
                AdrSrc = 1'b1;
                w_memw = 1'b1;
            end
            S_EXECR:  ALUControl = w_alu_dec;
            S_EXECI: begin
                ALUSrcB    = 2'b01;
                ALUControl = w_alu_dec;
            end
            S_ALUWB:  w_regw = 1'b1;
            S_BRANCH: begin
                ALUSrcB   = 2'b01;
                ResultSrc = 2'b10;
                w_br      = 1'b1;
                RegSrc[0] = 1'b1;
            end
            S_UNKNOWN: Illegal = 1'b1;
            S_EXECM:   ALUControl = 3'b100;
            default: ;
        endcase
        // STR reads Rd on port 2 throughout its own states (IR is stale in FETCH)
        RegSrc[1] = (r_state != S_FETCH) && (w_op == 2'b01) && !Instr[20];
    end

    assign ImmSrc   = Instr[27:26];
    assign State    = r_state;
    assign Busy     = (r_state == S_EXECM);
    assign MulSel   = w_is_mul && (r_state == S_DECODE || r_state == S_EXECM ||
                                   r_state == S_ALUWB);
    assign IRWrite  = reset && (r_state == S_FETCH);
    assign RegWrite = reset && w_regw && r_condex;
    assign MemWrite = reset && w_memw && r_condex;
    assign PCWrite  = reset && ((r_state == S_FETCH) ||
                      (r_condex && (w_br || (w_regw && Instr[15:12] == 4'd15))));

endmodule

`default_nettype wire
